// File: rtl/disp_demux_if.sv
// Bus bundle between a multiplexed seven-segment source and the demultiplexer.
// The slave side belongs to disp_demux.
// The master side belongs to whatever drives the display bus and reads the results.
interface disp_demux_if #(
    parameter int B = 8
);
    logic [B-1:0] sseg_in;
    logic [3:0]   an_in;
    logic [B-1:0] out0;
    logic [B-1:0] out1;
    logic [B-1:0] out2;
    logic [B-1:0] out3;
    logic [3:0]   valid;
    logic         frame_done;
    logic         err;
    logic         seq_err;

    modport slave (
        input  sseg_in,
        input  an_in,
        output out0,
        output out1,
        output out2,
        output out3,
        output valid,
        output frame_done,
        output err,
        output seq_err
    );

    modport master (
        output sseg_in,
        output an_in,
        input  out0,
        input  out1,
        input  out2,
        input  out3,
        input  valid,
        input  frame_done,
        input  err,
        input  seq_err
    );
endinterface

// File: rtl/disp_demux.sv
// Receiving end of a time-multiplexed 4-digit seven-segment bus.
// It registers the segment/anode pair and waits for STABLE identical samples.
// It then accepts the dwell and stores the segment word for the selected digit.
// It also flags illegal anode codes and checks that digits arrive in 0,1,2,3 order.
// STABLE is meaningful in the range 2..255.
module disp_demux #(
    parameter int B      = 8,
    parameter int STABLE = 4
) (
    input logic       clk,
    input logic       rst_n,
    disp_demux_if.slave bus
);

    localparam int             CW       = $clog2(STABLE + 1);
    localparam logic [CW-1:0]  STABLE_C = CW'(STABLE);

    typedef enum logic [1:0] {
        IDLE,
        EXP1,
        EXP2,
        EXP3
    } seq_state_t;

    logic [3:0]    r_sAn;
    logic [B-1:0]  r_sSeg;
    logic [CW-1:0] r_count;
    logic          r_fired;
    logic [B-1:0]  r_out0;
    logic [B-1:0]  r_out1;
    logic [B-1:0]  r_out2;
    logic [B-1:0]  r_out3;
    logic [3:0]    r_valid;
    logic          r_err;
    logic          r_frameDone;
    logic          r_seqErr;
    seq_state_t    r_state;

    logic          w_change;
    logic          w_accept;
    logic          w_isDigit;
    logic          w_isIllegal;
    logic [1:0]    w_digit;

    // A change is judged against the registered copy.
    // The counter therefore restarts on the same edge that loads the new pattern.
    assign w_change = ({bus.an_in, bus.sseg_in} != {r_sAn, r_sSeg});

    // A dwell is accepted once, on the first cycle the counter sits at STABLE.
    assign w_accept = (r_count == STABLE_C) && !r_fired;

    // Decode the registered anode code.
    // Blank (all anodes off) is neither a digit nor illegal.
    always_comb begin
        w_isDigit   = 1'b0;
        w_isIllegal = 1'b0;
        w_digit     = 2'd0;
        case (r_sAn)
            4'hE:    begin w_isDigit = 1'b1; w_digit = 2'd0; end
            4'hD:    begin w_isDigit = 1'b1; w_digit = 2'd1; end
            4'hB:    begin w_isDigit = 1'b1; w_digit = 2'd2; end
            4'h7:    begin w_isDigit = 1'b1; w_digit = 2'd3; end
            4'hF:    ;
            default: w_isIllegal = 1'b1;
        endcase
    end

    // Input stage: sample the bus once every clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sAn  <= 4'hF;
            r_sSeg <= '0;
        end else begin
            r_sAn  <= bus.an_in;
            r_sSeg <= bus.sseg_in;
        end
    end

    // Saturating stability counter, plus a flag that blocks a second accept within one dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_fired <= 1'b0;
        end else if (w_change) begin
            r_count <= CW'(1);
            r_fired <= 1'b0;
        end else begin
            if (r_count != STABLE_C) begin
                r_count <= r_count + CW'(1);
            end
            if (w_accept) begin
                r_fired <= 1'b1;
            end
        end
    end

    // Capture the accepted segment word, mark the digit valid, and pulse err on illegal codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out0  <= '0;
            r_out1  <= '0;
            r_out2  <= '0;
            r_out3  <= '0;
            r_valid <= 4'b0000;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_accept && w_isIllegal;
            if (w_accept && w_isDigit) begin
                r_valid[w_digit] <= 1'b1;
                case (w_digit)
                    2'd0:    r_out0 <= r_sSeg;
                    2'd1:    r_out1 <= r_sSeg;
                    2'd2:    r_out2 <= r_sSeg;
                    default: r_out3 <= r_sSeg;
                endcase
            end
        end
    end

    // Digit-order checker.
    // Digit 0 always starts a new frame.
    // Each state expects the next digit.
    // Any other nonzero digit aborts the frame with seq_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_frameDone <= 1'b0;
            r_seqErr    <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            r_seqErr    <= 1'b0;
            if (w_accept && w_isDigit) begin
                if (w_digit == 2'd0) begin
                    r_state <= EXP1;
                end else begin
                    case (r_state)
                        IDLE: r_state <= IDLE;
                        EXP1: begin
                            if (w_digit == 2'd1) begin
                                r_state <= EXP2;
                            end else begin
                                r_seqErr <= 1'b1;
                                r_state  <= IDLE;
                            end
                        end
                        EXP2: begin
                            if (w_digit == 2'd2) begin
                                r_state <= EXP3;
                            end else begin
                                r_seqErr <= 1'b1;
                                r_state  <= IDLE;
                            end
                        end
                        default: begin
                            if (w_digit == 2'd3) begin
                                r_frameDone <= 1'b1;
                            end else begin
                                r_seqErr <= 1'b1;
                            end
                            r_state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.out0       = r_out0;
    assign bus.out1       = r_out1;
    assign bus.out2       = r_out2;
    assign bus.out3       = r_out3;
    assign bus.valid      = r_valid;
    assign bus.frame_done = r_frameDone;
    assign bus.err        = r_err;
    assign bus.seq_err    = r_seqErr;

endmodule

// File: tb/tb_disp_demux.sv
// Directed bench for disp_demux with B=8 and STABLE=4.
// A table of dwells is applied first, and each dwell lists the expected outputs and pulse counts.
// Hand-written sequences then pin down exact edge timing, short dwells and reset.
module tb_disp_demux;

    logic clk;
    logic rst_n;

    disp_demux_if #(.B(8)) bus ();

    disp_demux #(
        .B(8),
        .STABLE(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        int         cycles;
        logic [7:0] exp0;
        logic [7:0] exp1;
        logic [7:0] exp2;
        logic [7:0] exp3;
        logic [3:0] expValid;
        int         expFrame;
        int         expErr;
        int         expSeq;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    int compared   = 0;
    int mismatched = 0;
    int frameCnt   = 0;
    int errCnt     = 0;
    int seqCnt     = 0;

    // The clock period is 10 time units.
    // Inputs are driven and outputs sampled on the falling edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count pulses shortly after each rising edge.
    // This runs before the falling edge where the test reads the counts.
    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            if (bus.frame_done) frameCnt++;
            if (bus.err)        errCnt++;
            if (bus.seq_err)    seqCnt++;
        end
    end

    // Drive one bus pattern and let it stand for n rising edges.
    // The task returns on the following falling edge.
    task automatic applyStimulus(input logic [3:0] an, input logic [7:0] seg, input int n);
        bus.an_in   = an;
        bus.sseg_in = seg;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        int f0;
        int e0;
        int s0;

        vecs[0]  = '{4'hE, 8'h3F, 25, 8'h3F, 8'h00, 8'h00, 8'h00, 4'b0001, 0, 0, 0};
        vecs[1]  = '{4'hD, 8'h06, 3,  8'h3F, 8'h00, 8'h00, 8'h00, 4'b0001, 0, 0, 0};
        vecs[2]  = '{4'hF, 8'h00, 8,  8'h3F, 8'h00, 8'h00, 8'h00, 4'b0001, 0, 0, 0};
        vecs[3]  = '{4'hE, 8'h11, 8,  8'h11, 8'h00, 8'h00, 8'h00, 4'b0001, 0, 0, 0};
        vecs[4]  = '{4'hD, 8'h22, 8,  8'h11, 8'h22, 8'h00, 8'h00, 4'b0011, 0, 0, 0};
        vecs[5]  = '{4'hB, 8'h33, 8,  8'h11, 8'h22, 8'h33, 8'h00, 4'b0111, 0, 0, 0};
        vecs[6]  = '{4'h7, 8'h44, 8,  8'h11, 8'h22, 8'h33, 8'h44, 4'b1111, 1, 0, 0};
        vecs[7]  = '{4'hE, 8'h55, 8,  8'h55, 8'h22, 8'h33, 8'h44, 4'b1111, 0, 0, 0};
        vecs[8]  = '{4'hB, 8'h66, 8,  8'h55, 8'h22, 8'h66, 8'h44, 4'b1111, 0, 0, 1};
        vecs[9]  = '{4'h7, 8'h77, 8,  8'h55, 8'h22, 8'h66, 8'h77, 4'b1111, 0, 0, 0};
        vecs[10] = '{4'hE, 8'h01, 8,  8'h01, 8'h22, 8'h66, 8'h77, 4'b1111, 0, 0, 0};
        vecs[11] = '{4'hD, 8'h02, 8,  8'h01, 8'h02, 8'h66, 8'h77, 4'b1111, 0, 0, 0};
        vecs[12] = '{4'hB, 8'h03, 8,  8'h01, 8'h02, 8'h03, 8'h77, 4'b1111, 0, 0, 0};
        vecs[13] = '{4'h7, 8'h04, 8,  8'h01, 8'h02, 8'h03, 8'h04, 4'b1111, 1, 0, 0};
        vecs[14] = '{4'h5, 8'h04, 10, 8'h01, 8'h02, 8'h03, 8'h04, 4'b1111, 0, 1, 0};
        vecs[15] = '{4'h5, 8'h09, 6,  8'h01, 8'h02, 8'h03, 8'h04, 4'b1111, 0, 1, 0};
        vecs[16] = '{4'h5, 8'h09, 3,  8'h01, 8'h02, 8'h03, 8'h04, 4'b1111, 0, 0, 0};
        vecs[17] = '{4'hD, 8'hAA, 8,  8'h01, 8'hAA, 8'h03, 8'h04, 4'b1111, 0, 0, 0};
        vecs[18] = '{4'hE, 8'hBB, 8,  8'hBB, 8'hAA, 8'h03, 8'h04, 4'b1111, 0, 0, 0};
        vecs[19] = '{4'h7, 8'hCC, 8,  8'hBB, 8'hAA, 8'h03, 8'hCC, 4'b1111, 0, 0, 1};
        vecs[20] = '{4'hE, 8'hDD, 8,  8'hDD, 8'hAA, 8'h03, 8'hCC, 4'b1111, 0, 0, 0};
        vecs[21] = '{4'hD, 8'hEE, 8,  8'hDD, 8'hEE, 8'h03, 8'hCC, 4'b1111, 0, 0, 0};
        vecs[22] = '{4'hE, 8'hFF, 8,  8'hFF, 8'hEE, 8'h03, 8'hCC, 4'b1111, 0, 0, 0};
        vecs[23] = '{4'hD, 8'h12, 8,  8'hFF, 8'h12, 8'h03, 8'hCC, 4'b1111, 0, 0, 0};
        vecs[24] = '{4'hB, 8'h13, 8,  8'hFF, 8'h12, 8'h13, 8'hCC, 4'b1111, 0, 0, 0};
        vecs[25] = '{4'h7, 8'h14, 8,  8'hFF, 8'h12, 8'h13, 8'h14, 4'b1111, 1, 0, 0};

        // Reset state
        rst_n       = 1'b0;
        bus.an_in   = 4'hF;
        bus.sseg_in = 8'h00;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset out0", 32'(bus.out0), 32'h0);
        checkOutput("reset out3", 32'(bus.out3), 32'h0);
        checkOutput("reset valid", 32'(bus.valid), 32'h0);
        checkOutput("reset pulses", {29'd0, bus.frame_done, bus.err, bus.seq_err}, 32'h0);
        rst_n = 1'b1;

        // Table-driven dwells
        for (int i = 0; i < NV; i++) begin
            f0 = frameCnt;
            e0 = errCnt;
            s0 = seqCnt;
            applyStimulus(vecs[i].an, vecs[i].seg, vecs[i].cycles);
            checkOutput($sformatf("v%0d out0", i), 32'(bus.out0), 32'(vecs[i].exp0));
            checkOutput($sformatf("v%0d out1", i), 32'(bus.out1), 32'(vecs[i].exp1));
            checkOutput($sformatf("v%0d out2", i), 32'(bus.out2), 32'(vecs[i].exp2));
            checkOutput($sformatf("v%0d out3", i), 32'(bus.out3), 32'(vecs[i].exp3));
            checkOutput($sformatf("v%0d valid", i), 32'(bus.valid), 32'(vecs[i].expValid));
            checkOutput($sformatf("v%0d frame_done count", i), 32'(frameCnt - f0), 32'(vecs[i].expFrame));
            checkOutput($sformatf("v%0d err count", i), 32'(errCnt - e0), 32'(vecs[i].expErr));
            checkOutput($sformatf("v%0d seq_err count", i), 32'(seqCnt - s0), 32'(vecs[i].expSeq));
        end

        // Exact latency: out0 changes at edge 4, not edge 3
        applyStimulus(4'hE, 8'h5A, 4);
        checkOutput("latency out0 before edge 4", 32'(bus.out0), 32'hFF);
        applyStimulus(4'hE, 8'h5A, 1);
        checkOutput("latency out0 after edge 4", 32'(bus.out0), 32'h5A);

        // A dwell of exactly STABLE samples is accepted on the edge where it ends
        s0 = seqCnt;
        applyStimulus(4'hB, 8'h7E, 4);
        checkOutput("4-sample dwell out2 pending", 32'(bus.out2), 32'h13);
        applyStimulus(4'hF, 8'h00, 1);
        checkOutput("4-sample dwell out2 accepted", 32'(bus.out2), 32'h7E);
        checkOutput("4-sample dwell seq_err in EXP1", 32'(seqCnt - s0), 32'd1);
        applyStimulus(4'hF, 8'h00, 4);

        // frame_done lands on the digit-3 accept edge and lasts one cycle
        applyStimulus(4'hE, 8'h61, 8);
        applyStimulus(4'hD, 8'h62, 8);
        applyStimulus(4'hB, 8'h63, 8);
        applyStimulus(4'h7, 8'h64, 4);
        checkOutput("frame_done before accept", 32'(bus.frame_done), 32'd0);
        checkOutput("out3 before accept", 32'(bus.out3), 32'h14);
        applyStimulus(4'h7, 8'h64, 1);
        checkOutput("frame_done at accept", 32'(bus.frame_done), 32'd1);
        checkOutput("out3 at accept", 32'(bus.out3), 32'h64);
        applyStimulus(4'h7, 8'h64, 1);
        checkOutput("frame_done one cycle", 32'(bus.frame_done), 32'd0);

        // A change at the saturating edge wins, so a 3-sample dwell is dropped
        applyStimulus(4'hD, 8'h3C, 3);
        applyStimulus(4'hF, 8'h00, 5);
        checkOutput("3-sample dwell out1 unchanged", 32'(bus.out1), 32'h62);

        // err pulse timing on an illegal code
        applyStimulus(4'h5, 8'h00, 4);
        checkOutput("err before edge 4", 32'(bus.err), 32'd0);
        applyStimulus(4'h5, 8'h00, 1);
        checkOutput("err at edge 4", 32'(bus.err), 32'd1);
        applyStimulus(4'h5, 8'h00, 1);
        checkOutput("err one cycle", 32'(bus.err), 32'd0);

        // Reset mid-dwell clears at once, and the held pattern needs fresh samples afterwards
        applyStimulus(4'hD, 8'h99, 2);
        rst_n       = 1'b0;
        bus.an_in   = 4'hE;
        bus.sseg_in = 8'h42;
        #1;
        checkOutput("mid reset out1", 32'(bus.out1), 32'h0);
        checkOutput("mid reset out3", 32'(bus.out3), 32'h0);
        checkOutput("mid reset valid", 32'(bus.valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'hE, 8'h42, 4);
        checkOutput("post reset out0 pending", 32'(bus.out0), 32'h0);
        checkOutput("post reset valid pending", 32'(bus.valid), 32'h0);
        applyStimulus(4'hE, 8'h42, 1);
        checkOutput("post reset out0", 32'(bus.out0), 32'h42);
        checkOutput("post reset valid", 32'(bus.valid), 32'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
